proj_coeff_unit: RTL and testbench

Parametrised Gram-Schmidt projection-coefficient engine for the eigenvalue QR datapath. It streams N-element signed fixed-point vectors ai and aj, accumulates the dot product ai^T·aj at full precision, rescales and saturates it, then divides by rii with an iterative restoring divider. The results are dot = ai^T·aj and rij = dot / rii. It replaces the fixed 4-lane multiplier/adder-tree/IP-divider path with one multiplier, a handshake interface, constant latency, and saturation/divide-by-zero reporting.

---
 rtl/proj_coeff_unit_if.sv | 28 ++
 rtl/proj_coeff_unit.sv | 177 +++++++++++++++++
 tb/tb_proj_coeff_unit.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/proj_coeff_unit_if.sv
// Handshake and data bundle for proj_coeff_unit: command, element stream and result.
interface proj_coeff_unit_if #(
  parameter int W = 16
);
  logic         start;
  logic [W-1:0] in_rii;
  logic         busy;
  logic         elem_valid;
  logic         elem_ready;
  logic [W-1:0] in_ai;
  logic [W-1:0] in_aj;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_dot;
  logic [W-1:0] out_rij;
  logic         out_sat;
  logic         out_dz;

  modport master (
    output start, in_rii, elem_valid, in_ai, in_aj, out_ready,
    input  busy, elem_ready, out_valid, out_dot, out_rij, out_sat, out_dz
  );

  modport slave (
    input  start, in_rii, elem_valid, in_ai, in_aj, out_ready,
    output busy, elem_ready, out_valid, out_dot, out_rij, out_sat, out_dz
  );
endinterface

// File: rtl/proj_coeff_unit.sv
// Gram-Schmidt projection coefficient: single-MAC dot product, rescale/saturate,
// then a constant-latency restoring divide by rii.
module proj_coeff_unit #(
  parameter int N    = 4,
  parameter int W    = 16,
  parameter int FRAC = 10
) (
  input logic              clk,
  input logic              rst_n,
  proj_coeff_unit_if.slave bus
);
  localparam int ACC_W = 2*W + $clog2(N);
  localparam int Q     = W - 1 + FRAC;
  localparam int BW    = $clog2(N + 1);
  localparam int CW    = $clog2(Q + 1);

  localparam logic signed [ACC_W-1:0] DMAX = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] DMIN = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, MAC, NORM, DIV, DONE} state_t;

  state_t                  state_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [BW-1:0]           beat_q;
  logic [CW-1:0]           cnt_q;
  logic [W-1:0]            rii_q, dot_q, div_q, rem_q;
  logic [Q-1:0]            dvd_q, quo_q;
  logic                    sat_dot_q, dz_q, sign_q, qtop_q;
  logic                    busy_q, ready_q, valid_q;
  logic [W-1:0]            out_dot_q, out_rij_q;
  logic                    out_sat_q, out_dz_q;

  logic signed [2*W-1:0]   a_s, b_s, prod;
  logic signed [ACC_W-1:0] shifted;
  logic [W-1:0]            dot_d, dot_mag, rii_mag, rem_init, rij_d, q_mag;
  logic                    clamp_d, qtop_d, ge, q_ovf, quo_sat;
  logic [Q:0]              dvd_full, q_full;
  logic [Q-1:0]            quo_nxt;
  logic [Q+W-1:0]          q_ext;
  logic [W:0]              t, rem_nxt;

  always_comb begin
    a_s  = (2*W)'($signed(bus.in_ai));
    b_s  = (2*W)'($signed(bus.in_aj));
    prod = a_s * b_s;
  end

  always_comb begin
    shifted = acc_q >>> FRAC;
    clamp_d = 1'b1;
    if (shifted > DMAX)      dot_d = SMAX;
    else if (shifted < DMIN) dot_d = SMIN;
    else begin
      dot_d   = shifted[W-1:0];
      clamp_d = 1'b0;
    end
    dot_mag  = dot_d[W-1] ? (~dot_d + 1'b1) : dot_d;
    rii_mag  = rii_q[W-1] ? (~rii_q + 1'b1) : rii_q;
    dvd_full = (Q+1)'(dot_mag) << FRAC;
    // Only |dot| = 2^(W-1) sets the dividend bit above the Q iterated bits;
    // it yields a quotient bit of its own only when the divisor is 1.
    qtop_d   = dot_mag[W-1] && (rii_mag == W'(1));
    rem_init = {{(W-1){1'b0}}, dot_mag[W-1] & ~qtop_d};
  end

  always_comb begin
    t       = {rem_q, dvd_q[Q-1]};
    ge      = (t >= {1'b0, div_q});
    rem_nxt = ge ? (t - {1'b0, div_q}) : t;
    q_full  = {quo_q, ge};
    quo_nxt = q_full[Q-1:0];
    q_ext   = (Q+W)'(quo_nxt);
    q_ovf   = qtop_q | (|q_ext[Q+W-1:W-1]);
    q_mag   = {1'b0, quo_nxt[W-2:0]};
    quo_sat = 1'b0;
    if (dz_q) begin
      if (dot_q == '0)    rij_d = '0;
      else if (dot_q[W-1]) rij_d = SMIN;
      else                 rij_d = SMAX;
    end else if (q_ovf) begin
      rij_d   = sign_q ? SMIN : SMAX;
      quo_sat = 1'b1;
    end else begin
      rij_d = sign_q ? (~q_mag + 1'b1) : q_mag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      beat_q    <= '0;
      cnt_q     <= '0;
      rii_q     <= '0;
      dot_q     <= '0;
      div_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      quo_q     <= '0;
      sat_dot_q <= 1'b0;
      dz_q      <= 1'b0;
      sign_q    <= 1'b0;
      qtop_q    <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      valid_q   <= 1'b0;
      out_dot_q <= '0;
      out_rij_q <= '0;
      out_sat_q <= 1'b0;
      out_dz_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          state_q <= MAC;
          rii_q   <= bus.in_rii;
          acc_q   <= '0;
          beat_q  <= '0;
          busy_q  <= 1'b1;
          ready_q <= 1'b1;
        end
        MAC: if (bus.elem_valid && ready_q) begin
          acc_q <= acc_q + ACC_W'(prod);
          if (beat_q == BW'(N - 1)) begin
            state_q <= NORM;
            ready_q <= 1'b0;
          end else begin
            beat_q <= beat_q + 1'b1;
          end
        end
        NORM: begin
          state_q   <= DIV;
          dot_q     <= dot_d;
          sat_dot_q <= clamp_d;
          div_q     <= rii_mag;
          dz_q      <= (rii_q == '0);
          sign_q    <= dot_d[W-1] ^ rii_q[W-1];
          qtop_q    <= qtop_d;
          rem_q     <= rem_init;
          dvd_q     <= dvd_full[Q-1:0];
          quo_q     <= '0;
          cnt_q     <= '0;
        end
        DIV: begin
          rem_q <= rem_nxt[W-1:0];
          dvd_q <= dvd_q << 1;
          quo_q <= quo_nxt;
          if (cnt_q == CW'(Q - 1)) begin
            state_q   <= DONE;
            valid_q   <= 1'b1;
            out_dot_q <= dot_q;
            out_rij_q <= rij_d;
            out_sat_q <= sat_dot_q | quo_sat;
            out_dz_q  <= dz_q;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: if (bus.out_ready) begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.elem_ready = ready_q;
  assign bus.out_valid  = valid_q;
  assign bus.out_dot    = out_dot_q;
  assign bus.out_rij    = out_rij_q;
  assign bus.out_sat    = out_sat_q;
  assign bus.out_dz     = out_dz_q;
endmodule

// File: tb/tb_proj_coeff_unit.sv
// Directed bench for proj_coeff_unit: an N=4 and an N=8 instance share one driver.
module tb_proj_coeff_unit;
  localparam int W    = 16;
  localparam int FRAC = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         sel, start, ev, ordy;
  logic [W-1:0] rii, ai, aj;
  logic [W-1:0] va [8];
  logic [W-1:0] vb [8];
  int           tests = 0;
  int           fails = 0;
  int unsigned  cyc = 0;
  int unsigned  last_edge, start_edge, vedge_s;

  always @(posedge clk) cyc <= cyc + 1;

  proj_coeff_unit_if #(.W(W)) b4 ();
  proj_coeff_unit_if #(.W(W)) b8 ();

  assign b4.start      = start & ~sel;
  assign b4.in_rii     = rii;
  assign b4.elem_valid = ev & ~sel;
  assign b4.in_ai      = ai;
  assign b4.in_aj      = aj;
  assign b4.out_ready  = ordy;
  assign b8.start      = start & sel;
  assign b8.in_rii     = rii;
  assign b8.elem_valid = ev & sel;
  assign b8.in_ai      = ai;
  assign b8.in_aj      = aj;
  assign b8.out_ready  = ordy;

  proj_coeff_unit #(.N(4), .W(W), .FRAC(FRAC)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  proj_coeff_unit #(.N(8), .W(W), .FRAC(FRAC)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));

  logic         o_busy, o_ready, o_valid, o_sat, o_dz;
  logic [W-1:0] o_dot, o_rij;
  assign o_busy  = sel ? b8.busy       : b4.busy;
  assign o_ready = sel ? b8.elem_ready : b4.elem_ready;
  assign o_valid = sel ? b8.out_valid  : b4.out_valid;
  assign o_dot   = sel ? b8.out_dot    : b4.out_dot;
  assign o_rij   = sel ? b8.out_rij    : b4.out_rij;
  assign o_sat   = sel ? b8.out_sat    : b4.out_sat;
  assign o_dz    = sel ? b8.out_dz     : b4.out_dz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},  32'(o_busy),  32'd0);
    chk({tag, "_ready"}, 32'(o_ready), 32'd0);
    chk({tag, "_valid"}, 32'(o_valid), 32'd0);
    chk({tag, "_dot"},   32'(o_dot),   32'd0);
    chk({tag, "_rij"},   32'(o_rij),   32'd0);
    chk({tag, "_sat"},   32'(o_sat),   32'd0);
    chk({tag, "_dz"},    32'(o_dz),    32'd0);
  endtask

  task automatic setv(input logic [4*W-1:0] a, input logic [4*W-1:0] b);
    for (int i = 0; i < 4; i++) begin
      va[i]   = a[(3-i)*W +: W];
      vb[i]   = b[(3-i)*W +: W];
      va[i+4] = va[i];
      vb[i+4] = vb[i];
    end
  endtask

  task automatic begin_op(input logic [W-1:0] r);
    @(negedge clk);
    start = 1'b1;
    rii   = r;
    @(negedge clk);
    start      = 1'b0;
    rii        = 16'h5A5A;
    start_edge = cyc;
    chk("busy_after_start",  32'(o_busy),  32'd1);
    chk("ready_after_start", 32'(o_ready), 32'd1);
  endtask

  task automatic send(input int n, input int gap, input bit pulse);
    int g;
    for (int i = 0; i < n; i++) begin
      ev = 1'b1;
      ai = va[i];
      aj = vb[i];
      g  = 0;
      while (!o_ready && g < 50) begin
        @(negedge clk);
        g++;
      end
      if (!o_ready) chk("ready_timeout", 32'(o_ready), 32'd1);
      @(negedge clk);
      last_edge = cyc;
      ev = 1'b0;
      if (i < n - 1) begin
        for (int k = 0; k < gap; k++) begin
          if (pulse && k == 1) start = 1'b1;
          @(negedge clk);
          start = 1'b0;
        end
      end
    end
  endtask

  task automatic wait_res(output int unsigned vedge);
    int g;
    g = 0;
    while (!o_valid && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("valid_seen", 32'(o_valid), 32'd1);
    vedge = cyc;
  endtask

  task automatic ack();
    ordy = 1'b1;
    @(negedge clk);
    ordy = 1'b0;
    chk("idle_after_ack",  32'(o_busy),  32'd0);
    chk("valid_after_ack", 32'(o_valid), 32'd0);
  endtask

  task automatic run(input string tag, input bit s, input int n, input logic [W-1:0] r,
                     input logic [W-1:0] edot, input logic [W-1:0] erij,
                     input logic esat, input logic edz);
    int unsigned vedge;
    sel = s;
    begin_op(r);
    send(n, 0, 1'b0);
    wait_res(vedge);
    chk({tag, "_lat"},   vedge - last_edge,  32'(W + FRAC));
    chk({tag, "_total"}, vedge - start_edge, 32'(n + W + FRAC));
    chk({tag, "_dot"},   32'(o_dot), 32'(edot));
    chk({tag, "_rij"},   32'(o_rij), 32'(erij));
    chk({tag, "_sat"},   32'(o_sat), 32'(esat));
    chk({tag, "_dz"},    32'(o_dz),  32'(edz));
    ack();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0; start = 1'b0; ev = 1'b0; ordy = 1'b0;
    rii = '0; ai = '0; aj = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    setv({4{16'h0400}}, {4{16'h0400}});
    run("s1", 1'b0, 4, 16'h0800, 16'h1000, 16'h0800, 1'b0, 1'b0);

    setv({16'h0600, 16'hF800, 16'h0200, 16'h0000}, {16'h0800, 16'h0400, 16'hF000, 16'h0C00});
    run("s2", 1'b0, 4, 16'h0200, 16'hFC00, 16'hF800, 1'b0, 1'b0);

    setv({4{16'h4000}}, {4{16'h4000}});
    run("ovf_pos", 1'b0, 4, 16'h0400, 16'h7FFF, 16'h7FFF, 1'b1, 1'b0);

    setv({4{16'h4000}}, {4{16'hC000}});
    run("ovf_neg", 1'b0, 4, 16'h0400, 16'h8000, 16'h8000, 1'b1, 1'b0);
    run("rii_one", 1'b0, 4, 16'h0001, 16'h8000, 16'h8000, 1'b1, 1'b0);

    setv({4{16'h0400}}, {4{16'h0400}});
    run("trunc_pos", 1'b0, 4, 16'h0C00, 16'h1000, 16'h0555, 1'b0, 1'b0);
    run("trunc_neg", 1'b0, 4, 16'hF400, 16'h1000, 16'hFAAB, 1'b0, 1'b0);
    run("dz_pos",    1'b0, 4, 16'h0000, 16'h1000, 16'h7FFF, 1'b0, 1'b1);

    setv({4{16'h0000}}, {4{16'h0400}});
    run("dz_zero", 1'b0, 4, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1);

    setv({4{16'h0400}}, {4{16'hFC00}});
    run("dz_neg", 1'b0, 4, 16'h0000, 16'hF000, 16'h8000, 1'b0, 1'b1);

    // Stalled stream, stray starts while busy, held result.
    setv({4{16'h0400}}, {4{16'h0400}});
    sel = 1'b0;
    begin_op(16'h0800);
    send(4, 3, 1'b1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_res(vedge_s);
    chk("stall_lat", vedge_s - last_edge, 32'(W + FRAC));
    for (int k = 0; k < 5; k++) begin
      if (k == 2) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("hold_valid", 32'(o_valid), 32'd1);
      chk("hold_dot",   32'(o_dot),   32'h1000);
      chk("hold_rij",   32'(o_rij),   32'h0800);
      chk("hold_flags", 32'({o_sat, o_dz}), 32'd0);
    end
    ack();
    repeat (3) @(negedge clk);
    chk("no_restart", 32'(o_busy), 32'd0);

    // Asynchronous reset in the middle of an accumulation.
    setv({16'h0600, 16'hF800, 16'h0200, 16'h0000}, {16'h0800, 16'h0400, 16'hF000, 16'h0C00});
    begin_op(16'h0200);
    send(2, 0, 1'b0);
    #1 rst_n = 1'b0;
    #1 chk_zero("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run("s2_after_rst", 1'b0, 4, 16'h0200, 16'hFC00, 16'hF800, 1'b0, 1'b0);

    setv({4{16'h0400}}, {4{16'h0400}});
    run("n8_s1", 1'b1, 8, 16'h0800, 16'h2000, 16'h1000, 1'b0, 1'b0);
    setv({16'h0600, 16'hF800, 16'h0200, 16'h0000}, {16'h0800, 16'h0400, 16'hF000, 16'h0C00});
    run("n8_s2", 1'b1, 8, 16'h0200, 16'hF800, 16'hF000, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
